// File: rtl/des_iter_ctrl_pkg.sv
// Shared definitions for the iterative DES controller.
//   - FSM state encoding, round count, key-schedule shift mask
//   - data widths (block, half block, key, key half, subkey)
//   - DES permutation / S-box tables and the combinational helpers built on
//     them: expansion, s_function, p_post_sf, p_key2, p_inverse.
// Table entries use DES bit numbering: entry n selects source bit n, where
// bit 1 is the MSB of the source word.
package des_iter_ctrl_pkg;

  localparam int ROUNDS = 16;
  localparam logic [15:0] ONE_SHIFT_MASK = 16'b1000000100000011;
  localparam int CNT_W = $clog2(ROUNDS);
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

  localparam int BLK    = 64;
  localparam int HALF   = 32;
  localparam int KEY    = 56;
  localparam int KHALF  = 28;
  localparam int SUBKEY = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int E_TBL [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  localparam int P_TBL [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int IPINV_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  // Each box is stored row-major: index = {b1, b6, b2..b5} of its 6-bit input.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [SUBKEY-1:0] expansion(input logic [HALF-1:0] r);
    logic [SUBKEY-1:0] o;
    o = '0;
    for (int j = 0; j < SUBKEY; j++) o[6'(SUBKEY-1-j)] = r[5'(HALF-E_TBL[j])];
    return o;
  endfunction

  function automatic logic [HALF-1:0] s_function(input logic [SUBKEY-1:0] x);
    logic [HALF-1:0] o;
    logic [5:0]      six;
    o = '0;
    for (int k = 0; k < 8; k++) begin
      six = x[6'(SUBKEY-1-6*k) -: 6];
      o[5'(HALF-1-4*k) -: 4] = 4'(SBOX[3'(k)][{six[5], six[0], six[4:1]}]);
    end
    return o;
  endfunction

  function automatic logic [HALF-1:0] p_post_sf(input logic [HALF-1:0] s);
    logic [HALF-1:0] o;
    o = '0;
    for (int j = 0; j < HALF; j++) o[5'(HALF-1-j)] = s[5'(HALF-P_TBL[j])];
    return o;
  endfunction

  // Input is {C, D}; C supplies DES key bits 1..28.
  function automatic logic [SUBKEY-1:0] p_key2(input logic [KEY-1:0] cd);
    logic [SUBKEY-1:0] o;
    o = '0;
    for (int j = 0; j < SUBKEY; j++) o[6'(SUBKEY-1-j)] = cd[6'(KEY-PC2_TBL[j])];
    return o;
  endfunction

  function automatic logic [BLK-1:0] p_inverse(input logic [BLK-1:0] x);
    logic [BLK-1:0] o;
    o = '0;
    for (int j = 0; j < BLK; j++) o[6'(BLK-1-j)] = x[6'(BLK-IPINV_TBL[j])];
    return o;
  endfunction

endpackage

// File: rtl/des_iter_ctrl_round_unit.sv
// des_round_unit: one combinational DES round plus its key-schedule step.
//   l_i/r_i     current block halves
//   c_i/d_i     current key halves
//   idx_i       round index 0..15
//   decrypt_i   1 = decrypt schedule (right rotate), 0 = encrypt (left rotate)
//   l_o/r_o     block halves after this round
//   c_o/d_o     rotated key halves (also used to form this round's subkey)
module des_round_unit
  import des_iter_ctrl_pkg::*;
(
  input  logic [HALF-1:0]  l_i,
  input  logic [HALF-1:0]  r_i,
  input  logic [KHALF-1:0] c_i,
  input  logic [KHALF-1:0] d_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic             decrypt_i,
  output logic [HALF-1:0]  l_o,
  output logic [HALF-1:0]  r_o,
  output logic [KHALF-1:0] c_o,
  output logic [KHALF-1:0] d_o
);

  // Decrypt starts from the loaded key unrotated: the 28 positions of the
  // encrypt schedule bring the key back to itself, so K16 equals the load.
  function automatic logic [KHALF-1:0] rot_half(input logic [KHALF-1:0] x,
                                                input logic dec, input logic first,
                                                input logic one);
    if (dec && first) return x;
    if (!dec) return one ? {x[KHALF-2:0], x[KHALF-1]} : {x[KHALF-3:0], x[KHALF-1:KHALF-2]};
    return one ? {x[0], x[KHALF-1:1]} : {x[1:0], x[KHALF-1:2]};
  endfunction

  logic              one_shift;
  logic              first_round;
  logic [SUBKEY-1:0] subkey;
  logic [HALF-1:0]   f_out;

  assign one_shift   = ONE_SHIFT_MASK[idx_i];
  assign first_round = (idx_i == '0);

  assign c_o    = rot_half(c_i, decrypt_i, first_round, one_shift);
  assign d_o    = rot_half(d_i, decrypt_i, first_round, one_shift);
  assign subkey = p_key2({c_o, d_o});
  assign f_out  = p_post_sf(s_function(expansion(r_i) ^ subkey));

  assign l_o = r_i;
  assign r_o = l_i ^ f_out;

endmodule

// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: iterative DES engine, one Feistel round per clock.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready only while IDLE)
//   in_block                 IP-permuted block, L = [63:32], R = [31:0]
//   in_key                   PC-1-permuted key, C = [27:0], D = [55:28]
//   in_decrypt               1 = decrypt schedule
//   out_valid/out_ready      output handshake, held under backpressure
//   out_block                p_inverse({R16, L16}), registered
//   busy                     high in ROUND or DONE
//   round_idx                debug: cnt in ROUND, 0 in IDLE, 15 in DONE
module des_iter_ctrl
  import des_iter_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK-1:0]   in_block,
  input  logic [KEY-1:0]   in_key,
  input  logic             in_decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK-1:0]   out_block,
  output logic             busy,
  output logic [CNT_W-1:0] round_idx
);

  state_e            state_q, state_d;
  logic [HALF-1:0]   l_q, l_d, r_q, r_d;
  logic [KHALF-1:0]  c_q, c_d, d_q, d_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic [BLK-1:0]    out_block_q, out_block_d;

  logic [HALF-1:0]   l_nx, r_nx;
  logic [KHALF-1:0]  c_nx, d_nx;

  des_round_unit u_round (
    .l_i       (l_q),
    .r_i       (r_q),
    .c_i       (c_q),
    .d_i       (d_q),
    .idx_i     (cnt_q),
    .decrypt_i (mode_q),
    .l_o       (l_nx),
    .r_o       (r_nx),
    .c_o       (c_nx),
    .d_o       (d_nx)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_block_q <= out_block_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted to its held value first,
    // so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_block_d = out_block_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          l_d     = in_block[BLK-1:HALF];
          r_d     = in_block[HALF-1:0];
          c_d     = in_key[KHALF-1:0];
          d_d     = in_key[KEY-1:KHALF];
          mode_d  = in_decrypt;
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        l_d   = l_nx;
        r_d   = r_nx;
        c_d   = c_nx;
        d_d   = d_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ROUND) begin
          // Capture the result on the last round so out_block is a flop
          // output for the whole DONE phase.
          out_block_d = p_inverse({r_nx, l_nx});
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered so it reads 0 during reset and rises together with IDLE.
    in_ready_d = (state_d == IDLE);
  end

  always_comb begin
    unique case (state_q)
      ROUND:   round_idx = cnt_q;
      DONE:    round_idx = LAST_ROUND;
      default: round_idx = '0;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ROUND) || (state_q == DONE);
  assign out_block = out_block_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Self-checking bench for des_iter_ctrl: directed steps with a scoreboard of
// expected output blocks and an independent DES reference model.
module tb_des_iter_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_block;
  logic [55:0] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_block;
  logic        busy;
  logic [3:0]  round_idx;

  des_iter_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_key     (in_key),
    .in_decrypt (in_decrypt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int xfers    = 0;
  logic [63:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && out_valid && out_ready) xfers <= xfers + 1;

  localparam logic [55:0] KAT_KEY = 56'h556678FF0CCAAF;
  localparam logic [63:0] KAT_IP  = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;

  // ---------------- reference model ----------------
  localparam int TB_SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int TB_E [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int TB_P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int TB_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                 41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int TB_IP [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int TB_S [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] tb_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[63-j] = x[64-TB_IP[j]];
    return y;
  endfunction

  // Inverse of IP derived by scattering through the IP table.
  function automatic logic [63:0] tb_ip_inv(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[64-TB_IP[j]] = x[63-j];
    return y;
  endfunction

  function automatic logic [31:0] tb_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, o;
    logic [5:0]  six;
    int row, col;
    for (int j = 0; j < 48; j++) e[47-j] = r[32-TB_E[j]];
    e = e ^ k;
    for (int b = 0; b < 8; b++) begin
      six = e[47-6*b -: 6];
      row = 2 * six[5] + six[0];
      col = six[4:1];
      s[31-4*b -: 4] = 4'(TB_S[b][row*16+col]);
    end
    for (int j = 0; j < 32; j++) o[31-j] = s[32-TB_P[j]];
    return o;
  endfunction

  // Input block is in the IP domain; result is IP^-1 of the preoutput.
  function automatic logic [63:0] ref_des(input logic [63:0] blk, input logic [55:0] key, input logic dec);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] ks [16];
    logic [31:0] l, r, t;
    c = key[27:0];
    d = key[55:28];
    for (int i = 0; i < 16; i++) begin
      c = (c << TB_SHIFTS[i]) | (c >> (28 - TB_SHIFTS[i]));
      d = (d << TB_SHIFTS[i]) | (d >> (28 - TB_SHIFTS[i]));
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[i][47-j] = cd[56-TB_PC2[j]];
    end
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ tb_f(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    return tb_ip_inv({r, l});
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] blk, input logic [55:0] key, input logic dec,
                      input logic keep_valid, output int acc_cyc);
    in_block   = blk;
    in_key     = key;
    in_decrypt = dec;
    in_valid   = 1'b1;
    for (int i = 0; i < 40 && in_ready !== 1'b1; i++) @(negedge clk);
    check("send_ready", in_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int at_cyc);
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    at_cyc = cyc;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    e = sb.pop_front();
    check(tag, out_block, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc, oc, prev_acc, x0;
    logic [55:0] key_r;
    logic [63:0] blk_r;

    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_key = '0; in_decrypt = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_out_block", out_block, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Encrypt known-answer vector with latency measurement.
    out_ready = 1'b1;
    sb.push_back(KAT_CT);
    send(KAT_IP, KAT_KEY, 1'b0, 1'b0, acc);
    check("enc_busy", busy, 1);
    check("enc_in_ready_low", in_ready, 0);
    wait_out("enc", oc);
    check("enc_latency", oc - acc, 17);
    check("enc_done_idx", round_idx, 15);
    pop_check("enc_block");
    @(negedge clk);
    check("enc_after_valid", out_valid, 0);
    check("enc_after_ready", in_ready, 1);

    // Decrypt known-answer vector.
    sb.push_back(KAT_PT);
    send(tb_ip(KAT_CT), KAT_KEY, 1'b1, 1'b0, acc);
    wait_out("dec", oc);
    check("dec_latency", oc - acc, 17);
    pop_check("dec_block");
    @(negedge clk);

    // Backpressure: DONE held for 10 cycles.
    out_ready = 1'b0;
    sb.push_back(KAT_CT);
    send(KAT_IP, KAT_KEY, 1'b0, 1'b0, acc);
    wait_out("bp", oc);
    x0 = xfers;
    pop_check("bp_block");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_block", out_block, KAT_CT);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
    end
    check("bp_no_xfer", xfers, x0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_one_xfer", xfers, x0 + 1);

    // Inputs changing while rounds are running.
    sb.push_back(KAT_CT);
    send(KAT_IP, KAT_KEY, 1'b0, 1'b0, acc);
    for (int i = 0; i < 15; i++) begin
      check("chg_in_ready", in_ready, 0);
      in_block   = {$urandom(), $urandom()};
      in_key     = 56'({$urandom(), $urandom()});
      in_decrypt = 1'($urandom());
      in_valid   = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out("chg", oc);
    pop_check("chg_block");
    @(negedge clk);

    // Reset in the middle of round 7 aborts the operation.
    x0 = xfers;
    send(KAT_IP, KAT_KEY, 1'b0, 1'b0, acc);
    for (int i = 0; i < 40 && round_idx !== 4'd7; i++) @(negedge clk);
    check("rst_reach_idx7", round_idx, 7);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_round_idx", round_idx, 0);
    check("mid_rst_out_block", out_block, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_no_xfer", xfers, x0);
    sb.push_back(KAT_CT);
    send(KAT_IP, KAT_KEY, 1'b0, 1'b0, acc);
    wait_out("post_rst", oc);
    pop_check("post_rst_block");
    @(negedge clk);

    // Back-to-back random blocks with out_ready tied high.
    prev_acc = 0;
    for (int b = 0; b < 3; b++) begin
      blk_r = {$urandom(), $urandom()};
      key_r = 56'({$urandom(), $urandom()});
      sb.push_back(ref_des(blk_r, key_r, 1'b0));
      send(blk_r, key_r, 1'b0, (b < 2), acc);
      if (b > 0) check("b2b_spacing", acc - prev_acc, 18);
      prev_acc = acc;
      wait_out("b2b", oc);
      pop_check("b2b_block");
      check("b2b_cd_wrap", {dut.d_q, dut.c_q}, key_r);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
